im_loader: RTL and testbench

Program loader that drives the write port of the instruction memory. It accepts a byte stream through a valid/ready handshake, assembles 16-bit instructions high byte first, and writes them to consecutive instruction memory addresses with a one-cycle write strobe. It sits between the host byte link (UART/debug port) and `Instr_Memory`. It holds `busy` while loading and raises `done` when the program is in place, so the processor can be released.

---
 rtl/im_loader.sv | 154 +++++++++++++++
 tb/tb_im_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: program loader for the instruction memory write port.
// Accepts a byte stream over valid/ready, takes the first byte as the word
// count N (0 means 256), assembles 16-bit words high byte first, and writes
// each word to consecutive addresses starting at BASE_ADDR.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a load (honoured only in IDLE or DONE)
//   byte_valid      byte_data holds a valid stream byte
//   byte_data       stream byte
//   byte_ready      loader accepts a byte this cycle
//   wr_instruction  word to the instruction memory
//   wr_add          instruction memory address
//   wr_enable       one-cycle write strobe per word
//   busy            load in progress
//   done            program in place, held until next start or reset
//   word_count      words written in the current or last load
module im_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [15:0] wr_instruction,
  output logic [7:0]  wr_add,
  output logic        wr_enable,
  output logic        busy,
  output logic        done,
  output logic [8:0]  word_count
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   wc_q, wc_d;
  logic [CW-1:0]   wc_inc;
  logic [AW-1:0]   add_q, add_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            byte_ready_q, byte_ready_d;
  logic            wr_enable_q, wr_enable_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer;

  // Handshake is qualified by the registered ready, which tracks the state.
  assign xfer   = byte_valid && byte_ready_q;
  assign wc_inc = CW'(wc_q + CW'(1));

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wc_d    = wc_q;
    add_d   = add_q;
    hi_d    = hi_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (xfer) begin
          // A count byte of zero encodes a full 256-word image.
          n_d     = (byte_data == '0) ? CW'(256) : CW'(byte_data);
          wc_d    = '0;
          add_d   = BASE_ADDR;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = byte_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          instr_d = {hi_q, byte_data};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address wraps naturally at 8 bits.
        add_d   = AW'(add_q + AW'(1));
        wc_d    = wc_inc;
        state_d = (wc_inc == n_q) ? S_DONE : S_HI;
      end
      S_DONE: begin
        if (start) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    byte_ready_d = (state_d == S_COUNT) || (state_d == S_HI) || (state_d == S_LO);
    wr_enable_d  = (state_d == S_WRITE);
    busy_d       = (state_d == S_COUNT) || (state_d == S_HI) ||
                   (state_d == S_LO)    || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      wc_q         <= '0;
      add_q        <= BASE_ADDR;
      hi_q         <= '0;
      instr_q      <= '0;
      byte_ready_q <= 1'b0;
      wr_enable_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      wc_q         <= wc_d;
      add_q        <= add_d;
      hi_q         <= hi_d;
      instr_q      <= instr_d;
      byte_ready_q <= byte_ready_d;
      wr_enable_q  <= wr_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready     = byte_ready_q;
  assign wr_instruction = instr_q;
  assign wr_add         = add_q;
  assign wr_enable      = wr_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader. Two instances share the stimulus: one at
// BASE_ADDR 00 and one at BASE_ADDR FE to exercise address wrap-around.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        byte_ready0, wr_enable0, busy0, done0;
  logic [15:0] wr_instr0;
  logic [7:0]  wr_add0;
  logic [8:0]  word_count0;
  logic        byte_ready1, wr_enable1, busy1, done1;
  logic [15:0] wr_instr1;
  logic [7:0]  wr_add1;
  logic [8:0]  word_count1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bad_we = 1'b0;

  logic [7:0]  stim[$];
  logic [7:0]  la0[$];
  logic [15:0] ld0[$];
  int          lc0[$];
  logic [7:0]  la1[$];
  logic [15:0] ld1[$];
  logic [15:0] mem [256];

  im_loader #(.BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready0), .wr_instruction(wr_instr0),
    .wr_add(wr_add0), .wr_enable(wr_enable0), .busy(busy0), .done(done0),
    .word_count(word_count0)
  );

  im_loader #(.BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready1), .wr_instruction(wr_instr1),
    .wr_add(wr_add1), .wr_enable(wr_enable1), .busy(busy1), .done(done1),
    .word_count(word_count1)
  );

  always #5 clk = ~clk;

  // Edge counter, write logger and instruction memory model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (wr_enable0) begin
      la0.push_back(wr_add0);
      ld0.push_back(wr_instr0);
      lc0.push_back(cyc);
      mem[wr_add0] = wr_instr0;
    end
    if (wr_enable1) begin
      la1.push_back(wr_add1);
      ld1.push_back(wr_instr1);
    end
    if (wr_enable0 && byte_ready0) bad_we = 1'b1;
  end

  task automatic clear_logs();
    la0.delete(); ld0.delete(); lc0.delete();
    la1.delete(); ld1.delete();
    bad_we = 1'b0;
  endtask

  // Pulse start for one edge; returns #1 after the sampling edge.
  task automatic do_start(output int e0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  // Present stim bytes in order, advancing only on an accepted transfer.
  task automatic feed(input bit gap);
    int i = 0;
    int guard = 0;
    bit r;
    while (i < stim.size() && guard < 4000) begin
      byte_valid = 1'b1;
      byte_data  = stim[i];
      r = byte_ready0;
      @(posedge clk); #1;
      guard++;
      if (r) begin
        i++;
        if (gap) begin
          byte_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    byte_valid = 1'b0;
    checks++;
    if (i != stim.size()) begin
      errors++;
      $display("FAIL feed_timeout: consumed %0d bytes, expected %0d", i, stim.size());
    end
  endtask

  task automatic wait_done(output int de);
    int g = 0;
    while (!done0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    de = cyc;
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b expected 1", done0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready0, wr_enable0, busy0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {byte_ready0, wr_enable0, busy0, done0});
    end
    checks++;
    if ({wr_instr0, wr_add0, word_count0} !== {16'h0000, 8'h00, 9'd0}) begin
      errors++;
      $display("FAIL reset_data0: got %h/%h/%0d expected 0000/00/0", wr_instr0, wr_add0, word_count0);
    end
    checks++;
    if (wr_add1 !== 8'hFE) begin
      errors++;
      $display("FAIL reset_add1: got %h expected fe", wr_add1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({byte_ready0, busy0} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start: ready/busy got %b expected 00", {byte_ready0, busy0});
    end
  endtask

  task automatic test_basic();
    int e0, de;
    logic [7:0]  ea[3] = '{8'h00, 8'h01, 8'h02};
    logic [7:0]  eb[3] = '{8'hFE, 8'hFF, 8'h00};
    logic [15:0] ed[3] = '{16'h4810, 16'h4A0A, 16'h4C02};
    clear_logs();
    do_start(e0);
    stim = '{8'h03, 8'h48, 8'h10, 8'h4A, 8'h0A, 8'h4C, 8'h02};
    feed(1'b0);
    wait_done(de);
    checks++;
    if (de - e0 != 10) begin
      errors++;
      $display("FAIL basic_done_latency: got %0d edges expected 10", de - e0);
    end
    checks++;
    if (lc0.size() < 1 || lc0[0] - e0 != 4) begin
      errors++;
      $display("FAIL basic_first_write: got edge %0d expected 4", lc0.size() ? lc0[0] - e0 : -1);
    end
    checks++;
    if (la0.size() != 3 || la1.size() != 3) begin
      errors++;
      $display("FAIL basic_write_count: got %0d/%0d expected 3/3", la0.size(), la1.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({la0[k], ld0[k]} !== {ea[k], ed[k]}) begin
          errors++;
          $display("FAIL basic_write%0d: got %h@%h expected %h@%h", k, ld0[k], la0[k], ed[k], ea[k]);
        end
        checks++;
        if (mem[ea[k]] !== ed[k]) begin
          errors++;
          $display("FAIL basic_readback%0d: got %h expected %h", k, mem[ea[k]], ed[k]);
        end
        checks++;
        if (la1[k] !== eb[k]) begin
          errors++;
          $display("FAIL wrap_basic_add%0d: got %h expected %h", k, la1[k], eb[k]);
        end
      end
    end
    checks++;
    if ({word_count0, busy0, wr_enable0} !== {9'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_final: wc/busy/we got %0d/%b/%b expected 3/0/0", word_count0, busy0, wr_enable0);
    end
  endtask

  task automatic test_wrap();
    int e0, de;
    logic [7:0]  eb[3] = '{8'hFE, 8'hFF, 8'h00};
    logic [15:0] ed[3] = '{16'h1111, 16'h2222, 16'h3333};
    clear_logs();
    do_start(e0);
    checks++;
    if ({done0, busy0} !== 2'b01) begin
      errors++;
      $display("FAIL restart_from_done: done/busy got %b expected 01", {done0, busy0});
    end
    stim = '{8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    feed(1'b0);
    wait_done(de);
    checks++;
    if (la1.size() != 3 || la0.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d/%0d expected 3/3", la1.size(), la0.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({la1[k], ld1[k]} !== {eb[k], ed[k]}) begin
          errors++;
          $display("FAIL wrap_write%0d: got %h@%h expected %h@%h", k, ld1[k], la1[k], ed[k], eb[k]);
        end
      end
      checks++;
      if (la0[0] !== 8'h00) begin
        errors++;
        $display("FAIL reload_base: got %h expected 00", la0[0]);
      end
    end
    checks++;
    if (wr_add1 !== 8'h01) begin
      errors++;
      $display("FAIL wrap_final_add: got %h expected 01", wr_add1);
    end
  endtask

  task automatic test_full_256();
    int e0, de;
    clear_logs();
    do_start(e0);
    stim.delete();
    stim.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      stim.push_back(8'(k) ^ 8'h5A);
      stim.push_back(8'(k));
    end
    feed(1'b0);
    wait_done(de);
    checks++;
    if (la0.size() != 256) begin
      errors++;
      $display("FAIL full_count: got %0d writes expected 256", la0.size());
    end else begin
      for (int k = 0; k < 256; k++) begin
        checks++;
        if ({la0[k], ld0[k]} !== {8'(k), 8'(k) ^ 8'h5A, 8'(k)}) begin
          errors++;
          $display("FAIL full_write%0d: got %h@%h expected %h@%h", k, ld0[k], la0[k],
                   {8'(k) ^ 8'h5A, 8'(k)}, 8'(k));
        end
      end
    end
    checks++;
    if ({word_count0, done0} !== {9'd256, 1'b1}) begin
      errors++;
      $display("FAIL full_final: wc/done got %0d/%b expected 256/1", word_count0, done0);
    end
  endtask

  task automatic test_gaps();
    int e0, de;
    logic [7:0]  ea[3] = '{8'h00, 8'h01, 8'h02};
    logic [15:0] ed[3] = '{16'h4810, 16'h4A0A, 16'h4C02};
    clear_logs();
    do_start(e0);
    stim = '{8'h03, 8'h48, 8'h10, 8'h4A, 8'h0A, 8'h4C, 8'h02};
    feed(1'b1);
    wait_done(de);
    checks++;
    if (la0.size() != 3) begin
      errors++;
      $display("FAIL gaps_count: got %0d writes expected 3", la0.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({la0[k], ld0[k]} !== {ea[k], ed[k]}) begin
          errors++;
          $display("FAIL gaps_write%0d: got %h@%h expected %h@%h", k, ld0[k], la0[k], ed[k], ea[k]);
        end
      end
    end
    checks++;
    if ({bad_we, word_count0} !== {1'b0, 9'd3}) begin
      errors++;
      $display("FAIL gaps_final: bad_we/wc got %b/%0d expected 0/3", bad_we, word_count0);
    end
  endtask

  task automatic test_start_ignored();
    int e0;
    clear_logs();
    do_start(e0);
    byte_valid = 1'b1; byte_data = 8'h02;
    @(posedge clk); #1;                       // count consumed, now HI
    byte_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // start pulsed in HI
    start = 1'b0;
    checks++;
    if ({byte_ready0, busy0, done0} !== 3'b110) begin
      errors++;
      $display("FAIL start_in_hi: ready/busy/done got %b expected 110", {byte_ready0, busy0, done0});
    end
    byte_valid = 1'b1; byte_data = 8'h11;
    @(posedge clk); #1;
    byte_data = 8'h22;
    @(posedge clk); #1;                       // now WRITE
    byte_data = 8'h33;
    checks++;
    if ({wr_enable0, byte_ready0} !== 2'b10) begin
      errors++;
      $display("FAIL write_cycle: we/ready got %b expected 10", {wr_enable0, byte_ready0});
    end
    @(posedge clk); #1;                       // held byte not taken; now HI
    checks++;
    if ({wr_enable0, byte_ready0} !== 2'b01) begin
      errors++;
      $display("FAIL after_write: we/ready got %b expected 01", {wr_enable0, byte_ready0});
    end
    @(posedge clk); #1;                       // 33 consumed, now LO
    byte_data = 8'h44;
    @(posedge clk); #1;                       // now WRITE
    byte_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({done0, word_count0} !== {1'b1, 9'd2}) begin
      errors++;
      $display("FAIL held_done: done/wc got %b/%0d expected 1/2", done0, word_count0);
    end
    checks++;
    if (la0.size() != 2 || {la0[0], ld0[0], la0[1], ld0[1]} !== {8'h00, 16'h1122, 8'h01, 16'h3344}) begin
      errors++;
      $display("FAIL held_writes: got %0d writes, expected 1122@00 3344@01", la0.size());
    end
  endtask

  task automatic test_reset_mid();
    int e0, de;
    clear_logs();
    do_start(e0);
    stim = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78};
    feed(1'b0);                               // now in the second WRITE
    checks++;
    if (wr_enable0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_write: we got %b expected 1", wr_enable0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready0, wr_enable0, busy0, done0, wr_instr0, wr_add0, word_count0, wr_add1} !==
        {4'b0000, 16'h0000, 8'h00, 9'd0, 8'hFE}) begin
      errors++;
      $display("FAIL async_reset: flags %b instr %h add %h wc %0d add1 %h, expected all reset values",
               {byte_ready0, wr_enable0, busy0, done0}, wr_instr0, wr_add0, word_count0, wr_add1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    do_start(e0);
    stim = '{8'h01, 8'hAB, 8'hCD};
    feed(1'b0);
    wait_done(de);
    checks++;
    if (la0.size() != 1 || la1.size() != 1 ||
        {la0[0], ld0[0], la1[0], ld1[0]} !== {8'h00, 16'hABCD, 8'hFE, 16'hABCD}) begin
      errors++;
      $display("FAIL reload_after_reset: got %0d/%0d writes, expected abcd@00 and abcd@fe",
               la0.size(), la1.size());
    end
    checks++;
    if (de - e0 != 4) begin
      errors++;
      $display("FAIL single_word_latency: got %0d edges expected 4", de - e0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_256();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
